// File: rtl/ca_engine_if.sv
// Handshake and data bundle for the elementary cellular-automaton engine.
// The controller side drives run control and the seed; the engine drives cell state and status.
interface ca_engine_if #(
    parameter int unsigned CELLS = 128,
    parameter int unsigned GEN_W = 16
);
    logic [7:0]       rule_i;
    logic             wrap_i;
    logic [GEN_W-1:0] num_gens_i;
    logic             start_i;
    logic             abort_i;
    logic             seed_load_i;
    logic [CELLS-1:0] seed_i;
    logic [CELLS-1:0] ca_o;
    logic             gen_valid_o;
    logic             done_o;
    logic             busy_o;
    logic [GEN_W-1:0] gen_cnt_o;

    modport master (
        output rule_i, wrap_i, num_gens_i, start_i, abort_i, seed_load_i, seed_i,
        input  ca_o, gen_valid_o, done_o, busy_o, gen_cnt_o
    );

    modport slave (
        input  rule_i, wrap_i, num_gens_i, start_i, abort_i, seed_load_i, seed_i,
        output ca_o, gen_valid_o, done_o, busy_o, gen_cnt_o
    );
endinterface

// File: rtl/ca_engine.sv
// 1-D elementary cellular-automaton engine. One cell is evaluated per clock into a shadow
// register; the full generation is then committed in a single cycle so ca_o is never mixed.
module ca_engine #(
    parameter int unsigned CELLS = 128,
    parameter int unsigned GEN_W = 16
) (
    input logic        clk,
    input logic        reset_n,
    ca_engine_if.slave bus
);
    localparam int unsigned IdxW = $clog2(CELLS);
    localparam int unsigned ExtW = $clog2(CELLS + 2);

    typedef enum logic [1:0] {StIdle, StScan, StCommit} state_e;

    state_e           state_q;
    logic [CELLS-1:0] ca_q;
    logic [CELLS-1:0] shadow_q;
    logic [IdxW-1:0]  idx_q;
    logic [GEN_W-1:0] remaining_q;
    logic [GEN_W-1:0] gen_cnt_q;
    logic [7:0]       rule_q;
    logic             wrap_q;
    logic             gen_valid_q;
    logic             done_q;
    logic             busy_q;

    logic [CELLS+1:0] ext;
    logic [2:0]       window;
    logic             cell_nxt;

    // Next value of the cell under scan; ext[j] holds c[j-1], so the ends carry the boundary.
    always_comb begin
        ext      = {wrap_q & ca_q[0], ca_q, wrap_q & ca_q[CELLS-1]};
        window   = ext[ExtW'(idx_q) +: 3];
        cell_nxt = rule_q[window];
    end

    // Run controller: seed load, start latch, per-cell scan, whole-generation commit, abort.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            ca_q        <= CELLS'(1) << (CELLS / 2);
            idx_q       <= '0;
            remaining_q <= '0;
            gen_cnt_q   <= '0;
            rule_q      <= 8'd182;
            wrap_q      <= 1'b0;
            gen_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            gen_valid_q <= 1'b0;
            done_q      <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.seed_load_i) begin
                        ca_q      <= bus.seed_i;
                        gen_cnt_q <= '0;
                    end else if (bus.start_i) begin
                        rule_q      <= bus.rule_i;
                        wrap_q      <= bus.wrap_i;
                        remaining_q <= bus.num_gens_i;
                        idx_q       <= '0;
                        if (bus.num_gens_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= StScan;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                StScan: begin
                    if (bus.abort_i) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        shadow_q[idx_q] <= cell_nxt;
                        if (idx_q == IdxW'(CELLS - 1)) begin
                            state_q <= StCommit;
                        end else begin
                            idx_q <= idx_q + IdxW'(1);
                        end
                    end
                end
                StCommit: begin
                    // Abort beats the commit: the shadow generation is simply dropped.
                    if (bus.abort_i) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        ca_q        <= shadow_q;
                        gen_cnt_q   <= gen_cnt_q + GEN_W'(1);
                        remaining_q <= remaining_q - GEN_W'(1);
                        gen_valid_q <= 1'b1;
                        idx_q       <= '0;
                        if (remaining_q == GEN_W'(1)) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StScan;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ca_o        = ca_q;
    assign bus.gen_valid_o = gen_valid_q;
    assign bus.done_o      = done_q;
    assign bus.busy_o      = busy_q;
    assign bus.gen_cnt_o   = gen_cnt_q;
endmodule

// File: tb/tb_ca_engine.sv
// Bench for ca_engine: three engines (5, 8 and 128 cells) share one stimulus stream and are
// compared cycle by cycle against a generation-level reference model.
module tb_ca_engine;
    localparam int NDUT  = 3;
    localparam int MAXG  = 4;
    localparam int GEN_W = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [7:0]       rule;
    logic             wrap;
    logic [GEN_W-1:0] num_gens;
    logic             start;
    logic             abort;
    logic             seed_load;
    logic [127:0]     seed;

    logic [127:0]     ca_obs   [NDUT];
    logic             gv_obs   [NDUT];
    logic             done_obs [NDUT];
    logic             busy_obs [NDUT];
    logic [GEN_W-1:0] cnt_obs  [NDUT];

    logic [127:0]     m_ca  [NDUT];
    logic [GEN_W-1:0] m_cnt [NDUT];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int N = (g == 0) ? 5 : (g == 1) ? 8 : 128;
        ca_engine_if #(.CELLS(N), .GEN_W(GEN_W)) bus ();
        assign bus.rule_i      = rule;
        assign bus.wrap_i      = wrap;
        assign bus.num_gens_i  = num_gens;
        assign bus.start_i     = start;
        assign bus.abort_i     = abort;
        assign bus.seed_load_i = seed_load;
        assign bus.seed_i      = seed[N-1:0];
        assign ca_obs[g]       = 128'(bus.ca_o);
        assign gv_obs[g]       = bus.gen_valid_o;
        assign done_obs[g]     = bus.done_o;
        assign busy_obs[g]     = bus.busy_o;
        assign cnt_obs[g]      = bus.gen_cnt_o;
        ca_engine #(.CELLS(N), .GEN_W(GEN_W)) u_dut (
            .clk     (clk),
            .reset_n (reset_n),
            .bus     (bus)
        );
    end

    function automatic int cells_of(input int g);
        return (g == 0) ? 5 : (g == 1) ? 8 : 128;
    endfunction

    function automatic logic [127:0] mask_of(input int n);
        return (n >= 128) ? {128{1'b1}} : ((128'(1) << n) - 128'(1));
    endfunction

    // One generation straight from the rule table: neighbourhood {right, self, left}.
    function automatic logic [127:0] ref_step(input logic [127:0] c, input int n,
                                              input logic [7:0] r, input bit w);
        logic [127:0] nx;
        logic         lft;
        logic         rgt;
        nx = '0;
        for (int i = 0; i < n; i++) begin
            lft   = (i == 0) ? (w ? c[n-1] : 1'b0) : c[i-1];
            rgt   = (i == n - 1) ? (w ? c[0] : 1'b0) : c[i+1];
            nx[i] = r[{rgt, c[i], lft}];
        end
        return nx;
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_all(input string tag);
        for (int g = 0; g < NDUT; g++) begin
            int n = cells_of(g);
            m_ca[g]  = 128'(1) << (n / 2);
            m_cnt[g] = '0;
            check_eq($sformatf("%s ca n=%0d", tag, n), ca_obs[g], m_ca[g]);
            check_eq($sformatf("%s gen_cnt n=%0d", tag, n), 128'(cnt_obs[g]), 128'(0));
            check_eq($sformatf("%s busy n=%0d", tag, n), 128'(busy_obs[g]), 128'(0));
            check_eq($sformatf("%s gen_valid n=%0d", tag, n), 128'(gv_obs[g]), 128'(0));
            check_eq($sformatf("%s done n=%0d", tag, n), 128'(done_obs[g]), 128'(0));
        end
    endtask

    // Seed load in idle; optionally with start (must lose) and/or abort (must be ignored).
    task automatic load_seed(input logic [127:0] s, input bit with_start, input bit with_abort);
        seed      = s;
        seed_load = 1'b1;
        start     = with_start;
        abort     = with_abort;
        num_gens  = GEN_W'(1);
        @(posedge clk); #1;
        seed_load = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        for (int g = 0; g < NDUT; g++) begin
            int n = cells_of(g);
            m_ca[g]  = s & mask_of(n);
            m_cnt[g] = '0;
            check_eq($sformatf("seed ca n=%0d", n), ca_obs[g], m_ca[g]);
            check_eq($sformatf("seed gen_cnt n=%0d", n), 128'(cnt_obs[g]), 128'(0));
            check_eq($sformatf("seed busy n=%0d", n), 128'(busy_obs[g]), 128'(0));
        end
        @(posedge clk); #1;
        for (int g = 0; g < NDUT; g++) begin
            check_eq($sformatf("seed idle busy n=%0d", cells_of(g)), 128'(busy_obs[g]), 128'(0));
            check_eq($sformatf("seed idle done n=%0d", cells_of(g)), 128'(done_obs[g]), 128'(0));
        end
    endtask

    // Start a run and check every cycle. abort_at / rst_at are edge offsets from the
    // start-accept edge (0 = none). poke pulses start+seed_load while all engines are busy.
    task automatic run(input logic [7:0] r, input bit w, input int gens, input int abort_at,
                       input int rst_at, input bit poke);
        logic [127:0] exp_ca [NDUT][MAXG+1];
        int           nd   [NDUT];
        int           endc [NDUT];
        int           maxc;
        bit           poke_ok;
        bit           did_rst;
        rule     = r;
        wrap     = w;
        num_gens = GEN_W'(gens);
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        rule     = 8'($urandom);
        wrap     = 1'($urandom);
        num_gens = GEN_W'($urandom);
        maxc     = 2;
        did_rst  = 1'b0;
        poke_ok  = poke && gens > 0 && (abort_at == 0 || abort_at >= 2);
        for (int g = 0; g < NDUT; g++) begin
            int n    = cells_of(g);
            int last = gens * (n + 1);
            bit ab   = gens > 0 && abort_at > 0 && abort_at <= last;
            exp_ca[g][0] = m_ca[g];
            for (int k = 1; k <= gens; k++) exp_ca[g][k] = ref_step(exp_ca[g][k-1], n, r, w);
            nd[g]   = ab ? (abort_at - 1) / (n + 1) : gens;
            endc[g] = ab ? abort_at : last;
            if (endc[g] + 2 > maxc) maxc = endc[g] + 2;
        end
        if (rst_at > 0) maxc = rst_at;
        for (int c = 0; c <= maxc; c++) begin
            if (rst_at > 0 && c == rst_at) begin
                reset_n = 1'b1;
                check_reset_all("mid-run reset");
                did_rst = 1'b1;
                break;
            end
            for (int g = 0; g < NDUT; g++) begin
                int n      = cells_of(g);
                int per    = n + 1;
                int landed = (c / per > nd[g]) ? nd[g] : c / per;
                bit gv_exp = c > 0 && c % per == 0 && c / per <= nd[g];
                bit dn_exp = (gens == 0) ? (c == 0) : (nd[g] == gens && c == gens * per);
                check_eq($sformatf("ca n=%0d c=%0d", n, c), ca_obs[g], exp_ca[g][landed]);
                check_eq($sformatf("gen_cnt n=%0d c=%0d", n, c), 128'(cnt_obs[g]),
                         128'(m_cnt[g] + GEN_W'(landed)));
                check_eq($sformatf("busy n=%0d c=%0d", n, c), 128'(busy_obs[g]),
                         128'(c < endc[g]));
                check_eq($sformatf("gen_valid n=%0d c=%0d", n, c), 128'(gv_obs[g]),
                         128'(gv_exp));
                check_eq($sformatf("done n=%0d c=%0d", n, c), 128'(done_obs[g]),
                         128'(dn_exp));
            end
            abort     = (c + 1 == abort_at);
            reset_n   = !(rst_at > 0 && c + 1 == rst_at);
            start     = poke_ok && c == 1;
            seed_load = poke_ok && c == 1;
            if (poke_ok && c == 1) seed = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
        end
        abort     = 1'b0;
        start     = 1'b0;
        seed_load = 1'b0;
        reset_n   = 1'b1;
        if (!did_rst) begin
            for (int g = 0; g < NDUT; g++) begin
                m_ca[g]  = exp_ca[g][nd[g]];
                m_cnt[g] = m_cnt[g] + GEN_W'(nd[g]);
            end
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        rule      = '0;
        wrap      = 1'b0;
        num_gens  = '0;
        start     = 1'b0;
        abort     = 1'b0;
        seed_load = 1'b0;
        seed      = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check_reset_all("reset");

        run(8'd182, 1'b0, 1, 0, 0, 1'b0);
        load_seed(128'h10, 1'b0, 1'b0);
        run(8'd90, 1'b0, 2, 0, 0, 1'b0);
        load_seed(128'h01, 1'b1, 1'b0);
        run(8'd90, 1'b0, 1, 0, 0, 1'b0);
        load_seed(128'h01, 1'b0, 1'b1);
        run(8'd90, 1'b1, 1, 0, 0, 1'b0);
        run(8'd30, 1'b0, 0, 0, 0, 1'b0);
        load_seed({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        run(8'd110, 1'b1, 3, 14, 0, 1'b1);
        run(8'd30, 1'b1, 2, 0, 40, 1'b1);
        run(8'd150, 1'b0, 1, 0, 3, 1'b0);

        for (int it = 0; it < 30; it++) begin
            int gens = $urandom_range(0, 3);
            int ab   = 0;
            int rs   = 0;
            if ($urandom_range(0, 9) < 3) begin
                load_seed({$urandom, $urandom, $urandom, $urandom},
                          1'($urandom), 1'($urandom));
            end
            if ($urandom_range(0, 2) == 0) ab = $urandom_range(1, gens * 9 + 12);
            else if ($urandom_range(0, 5) == 0) rs = $urandom_range(1, gens * 20 + 5);
            run(8'($urandom), 1'($urandom), gens, ab, rs, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
